mux_key: RTL and testbench

//   Parameterised key->value lookup multiplexer: compares an input key against NR_KEY (key,data) pairs packed in a flat LUT bus and returns the matching data.

---
 rtl/mux_key.sv | 64 ++++++
 tb/tb_mux_key.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_key.sv
// Key->value lookup mux over a flat packed LUT of {key, data} pairs.
// Combinational out/hit plus a registered copy (out_q/hit_q) for pipelined users.
module mux_key #(
   parameter int NR_KEY      = 2,
   parameter int KEY_LEN     = 1,
   parameter int DATA_LEN    = 1,
   parameter int HAS_DEFAULT = 0
) (
   input  logic                                 i_clk,
   input  logic                                 i_rst,
   input  logic [KEY_LEN-1:0]                   key,
   input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
   input  logic [DATA_LEN-1:0]                  default_out,
   output logic [DATA_LEN-1:0]                  out,
   output logic                                 hit,
   output logic [DATA_LEN-1:0]                  out_q,
   output logic                                 hit_q
);

   localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

   logic [NR_KEY-1:0]   match;
   logic [DATA_LEN-1:0] masked_data [NR_KEY];
   logic [DATA_LEN-1:0] lut_out;
   logic [DATA_LEN-1:0] miss_val;
   logic [DATA_LEN-1:0] out_q_d;
   logic                hit_q_d;

   for (genvar i = 0; i < NR_KEY; i++) begin : g_pair
      logic [KEY_LEN-1:0]  pair_key;
      logic [DATA_LEN-1:0] pair_data;
      assign pair_key       = lut[PAIR_LEN*i+DATA_LEN +: KEY_LEN];
      assign pair_data      = lut[PAIR_LEN*i +: DATA_LEN];
      assign match[i]       = (key == pair_key);
      assign masked_data[i] = {DATA_LEN{match[i]}} & pair_data;
   end

   // Duplicate keys merge by OR, so pair order never matters.
   always_comb begin
      lut_out = '0;
      for (int i = 0; i < NR_KEY; i++) begin
         lut_out = lut_out | masked_data[i];
      end
   end

   assign hit      = |match;
   assign miss_val = (HAS_DEFAULT != 0) ? default_out : '0;
   assign out      = hit ? lut_out : miss_val;

   always_comb begin
      out_q_d = out;
      hit_q_d = hit;
      if (!i_rst) begin
         out_q_d = '0;
         hit_q_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      out_q <= out_q_d;
      hit_q <= hit_q_d;
   end

endmodule

// File: tb/tb_mux_key.sv
// Directed self-checking bench for mux_key: decode LUT, default handling,
// 64-bit lane-shift LUT, duplicate keys, registered path and reset.
module tb_mux_key;

   logic        clk;
   logic        rst_n;
   logic [2:0]  key3;
   logic [7:0]  dflt8;
   logic [63:0] dflt64;
   logic        key1;

   logic [7*11-1:0] lut7;
   logic [8*67-1:0] lut_lane;
   logic [2*9-1:0]  lut_dup;

   logic [7:0]  out7,   out7_q,   out7d,  out7d_q, outdup, outdup_q;
   logic        hit7,   hit7_q,   hit7d,  hit7d_q, hitdup, hitdup_q;
   logic [63:0] outl,   outl_q;
   logic        hitl,   hitl_q;

   int n_checks;
   int n_fail;

   mux_key #(.NR_KEY(7), .KEY_LEN(3), .DATA_LEN(8), .HAS_DEFAULT(0)) u_dec (
      .i_clk(clk), .i_rst(rst_n), .key(key3), .lut(lut7), .default_out(dflt8),
      .out(out7), .hit(hit7), .out_q(out7_q), .hit_q(hit7_q));

   mux_key #(.NR_KEY(7), .KEY_LEN(3), .DATA_LEN(8), .HAS_DEFAULT(1)) u_dec_def (
      .i_clk(clk), .i_rst(rst_n), .key(key3), .lut(lut7), .default_out(dflt8),
      .out(out7d), .hit(hit7d), .out_q(out7d_q), .hit_q(hit7d_q));

   mux_key #(.NR_KEY(8), .KEY_LEN(3), .DATA_LEN(64), .HAS_DEFAULT(0)) u_lane (
      .i_clk(clk), .i_rst(rst_n), .key(key3), .lut(lut_lane), .default_out(dflt64),
      .out(outl), .hit(hitl), .out_q(outl_q), .hit_q(hitl_q));

   mux_key #(.NR_KEY(2), .KEY_LEN(1), .DATA_LEN(8), .HAS_DEFAULT(0)) u_dup (
      .i_clk(clk), .i_rst(rst_n), .key(key1), .lut(lut_dup), .default_out(dflt8),
      .out(outdup), .hit(hitdup), .out_q(outdup_q), .hit_q(hitdup_q));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst_n = 1'b0;
      key3  = 3'd4;
      @(posedge clk); #1;
      n_checks++;
      if (out7_q !== 8'h00) begin
         n_fail++; $display("FAIL reset_out_q: got %h expected %h", out7_q, 8'h00);
      end
      n_checks++;
      if (hit7_q !== 1'b0) begin
         n_fail++; $display("FAIL reset_hit_q: got %b expected %b", hit7_q, 1'b0);
      end
      n_checks++;
      if (outl_q !== 64'h0) begin
         n_fail++; $display("FAIL reset_lane_out_q: got %h expected %h", outl_q, 64'h0);
      end
   endtask

   task automatic test_lookup();
      key3 = 3'b100; #1;
      n_checks++;
      if (out7 !== 8'h0F || hit7 !== 1'b1) begin
         n_fail++; $display("FAIL lookup_k4: got %h/%b expected %h/%b", out7, hit7, 8'h0F, 1'b1);
      end
      key3 = 3'b110; #1;
      n_checks++;
      if (out7 !== 8'hFF || hit7 !== 1'b1) begin
         n_fail++; $display("FAIL lookup_k6: got %h/%b expected %h/%b", out7, hit7, 8'hFF, 1'b1);
      end
      key3 = 3'b010; #1;
      n_checks++;
      if (out7 !== 8'h03) begin
         n_fail++; $display("FAIL lookup_k2: got %h expected %h", out7, 8'h03);
      end
      key3 = 3'b000; #1;
      n_checks++;
      if (out7 !== 8'h01) begin
         n_fail++; $display("FAIL lookup_k0: got %h expected %h", out7, 8'h01);
      end
   endtask

   task automatic test_miss_default();
      dflt8 = 8'hAA;
      key3  = 3'b111; #1;
      n_checks++;
      if (out7 !== 8'h00 || hit7 !== 1'b0) begin
         n_fail++; $display("FAIL miss_nodefault: got %h/%b expected %h/%b", out7, hit7, 8'h00, 1'b0);
      end
      n_checks++;
      if (out7d !== 8'hAA || hit7d !== 1'b0) begin
         n_fail++; $display("FAIL miss_default: got %h/%b expected %h/%b", out7d, hit7d, 8'hAA, 1'b0);
      end
      key3 = 3'b101; #1;
      n_checks++;
      if (out7d !== 8'h0F || hit7d !== 1'b1) begin
         n_fail++; $display("FAIL hit_with_default: got %h/%b expected %h/%b", out7d, hit7d, 8'h0F, 1'b1);
      end
   endtask

   task automatic test_lane_shift();
      key3 = 3'd3; #1;
      n_checks++;
      if (outl !== 64'h4455667788000000 || hitl !== 1'b1) begin
         n_fail++; $display("FAIL lane_k3: got %h expected %h", outl, 64'h4455667788000000);
      end
      key3 = 3'd7; #1;
      n_checks++;
      if (outl !== 64'h8800000000000000) begin
         n_fail++; $display("FAIL lane_k7: got %h expected %h", outl, 64'h8800000000000000);
      end
      key3 = 3'd0; #1;
      n_checks++;
      if (outl !== 64'h1122334455667788) begin
         n_fail++; $display("FAIL lane_k0: got %h expected %h", outl, 64'h1122334455667788);
      end
   endtask

   task automatic test_duplicate();
      key1 = 1'b1; #1;
      n_checks++;
      if (outdup !== 8'hFF || hitdup !== 1'b1) begin
         n_fail++; $display("FAIL dup_or: got %h/%b expected %h/%b", outdup, hitdup, 8'hFF, 1'b1);
      end
      key1 = 1'b0; #1;
      n_checks++;
      if (outdup !== 8'h00 || hitdup !== 1'b0) begin
         n_fail++; $display("FAIL dup_miss: got %h/%b expected %h/%b", outdup, hitdup, 8'h00, 1'b0);
      end
      lut_dup = {1'b0, 8'h3C, 1'b1, 8'h0F}; #1;
      n_checks++;
      if (outdup !== 8'h3C || hitdup !== 1'b1) begin
         n_fail++; $display("FAIL lut_change: got %h/%b expected %h/%b", outdup, hitdup, 8'h3C, 1'b1);
      end
   endtask

   task automatic test_registered();
      rst_n = 1'b1;
      key3  = 3'd4;
      @(posedge clk); #1;
      n_checks++;
      if (out7_q !== 8'h0F || hit7_q !== 1'b1) begin
         n_fail++; $display("FAIL reg_capture: got %h/%b expected %h/%b", out7_q, hit7_q, 8'h0F, 1'b1);
      end
      key3 = 3'd7; #1;
      n_checks++;
      if (out7_q !== 8'h0F || hit7_q !== 1'b1) begin
         n_fail++; $display("FAIL reg_hold: got %h/%b expected %h/%b", out7_q, hit7_q, 8'h0F, 1'b1);
      end
      @(posedge clk); #1;
      n_checks++;
      if (out7_q !== 8'h00 || hit7_q !== 1'b0) begin
         n_fail++; $display("FAIL reg_update: got %h/%b expected %h/%b", out7_q, hit7_q, 8'h00, 1'b0);
      end
      n_checks++;
      if (outl_q !== 64'h8800000000000000 || hitl_q !== 1'b1) begin
         n_fail++; $display("FAIL reg_lane: got %h expected %h", outl_q, 64'h8800000000000000);
      end
   endtask

   task automatic test_reset_mid();
      key3 = 3'd4;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (out7_q !== 8'h00 || hit7_q !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset_clear: got %h/%b expected %h/%b", out7_q, hit7_q, 8'h00, 1'b0);
      end
      n_checks++;
      if (out7 !== 8'h0F || hit7 !== 1'b1) begin
         n_fail++; $display("FAIL comb_during_reset: got %h/%b expected %h/%b", out7, hit7, 8'h0F, 1'b1);
      end
      @(posedge clk); #1;
      n_checks++;
      if (out7_q !== 8'h00) begin
         n_fail++; $display("FAIL reset_held: got %h expected %h", out7_q, 8'h00);
      end
      rst_n = 1'b1; #1;
      n_checks++;
      if (out7_q !== 8'h00) begin
         n_fail++; $display("FAIL release_no_edge: got %h expected %h", out7_q, 8'h00);
      end
      @(posedge clk); #1;
      n_checks++;
      if (out7_q !== 8'h0F || hit7_q !== 1'b1) begin
         n_fail++; $display("FAIL release_resume: got %h/%b expected %h/%b", out7_q, hit7_q, 8'h0F, 1'b1);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      key3     = 3'd0;
      key1     = 1'b0;
      dflt8    = 8'h55;
      dflt64   = 64'hDEAD_BEEF_0000_0001;
      lut7     = {3'd0, 8'h01, 3'd1, 8'h01, 3'd2, 8'h03, 3'd3, 8'h03,
                  3'd4, 8'h0F, 3'd5, 8'h0F, 3'd6, 8'hFF};
      lut_dup  = {1'b1, 8'hF0, 1'b1, 8'h0F};
      lut_lane = '0;
      for (int i = 0; i < 8; i++) begin
         lut_lane[67*i +: 67] = {3'(i), 64'h1122334455667788 << (8*i)};
      end

      test_reset();
      test_lookup();
      test_miss_default();
      test_lane_shift();
      test_duplicate();
      test_registered();
      test_reset_mid();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
